// File: rtl/pci_protocol_monitor.sv
// pci_protocol_monitor: passive PCI bus observer.
// Follows each transaction through IDLE/DATA/TURN, counts data beats, and raises
// sticky error flags for protocol rule violations, parity mismatches and master aborts.
// Optional X/Z sanity checks on AD/C_BE_ are compiled in when PCI_MON_XCHECK_EN is defined
// (simulation only); the synthesizable behaviour and ports are identical either way.

module pci_protocol_monitor #(
    parameter int AD_WIDTH       = 32,
    parameter int CBE_WIDTH      = AD_WIDTH / 8,
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 FRAME_,
    input  logic                 IRDY_,
    input  logic                 TRDY_,
    input  logic                 DEVSEL_,
    input  logic [CBE_WIDTH-1:0] C_BE_,
    input  logic [AD_WIDTH-1:0]  AD,
    input  logic                 PAR,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [3:0]           cmd,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic                 txn_done,
    output logic [4:0]           err_flags,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int                   TMO_WIDTH = $clog2(DEVSEL_TIMEOUT + 1);
    localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(DEVSEL_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic [3:0]             cmd_q, cmd_d;
    logic [CNT_WIDTH-1:0]   beatCount_q, beatCount_d;
    logic                   txnDone_q, txnDone_d;
    logic [4:0]             errFlags_q, errFlags_d;
    logic [CNT_WIDTH-1:0]   errCount_q, errCount_d;
    logic [TMO_WIDTH-1:0]   tmoCount_q, tmoCount_d;
    logic                   aborted_q, aborted_d;
    logic                   parPending_q, parPending_d;
    logic                   framePrev_q;
    logic [AD_WIDTH-1:0]    adPrev_q;
    logic [CBE_WIDTH-1:0]   cbePrev_q;

    logic                   addrPhase;
    logic                   transfer;
    logic [4:0]             newErr;
    logic [TMO_WIDTH-1:0]   tmoInc;
    logic [CNT_WIDTH-1:0]   beatInc;
    logic [CNT_WIDTH-1:0]   errInc;

    assign tmoInc  = tmoCount_q + 1'b1;
    assign beatInc = beatCount_q + 1'b1;
    assign errInc  = errCount_q + 1'b1;

    // Next-state decode: transaction FSM, beat/timeout counters and per-cycle error detection.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        beatCount_d  = beatCount_q;
        txnDone_d    = 1'b0;
        tmoCount_d   = tmoCount_q;
        aborted_d    = aborted_q;
        newErr       = '0;
        addrPhase    = 1'b0;
        transfer     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!FRAME_) begin
                    addrPhase = 1'b1;
                end
                if (!IRDY_ && FRAME_) begin
                    newErr[4] = 1'b1;
                end
            end
            DATA: begin
                transfer = !IRDY_ && !TRDY_;
                if (transfer && (beatCount_q != CNT_MAX)) begin
                    beatCount_d = beatInc;
                end
                if (aborted_q) begin
                    // After a master abort only the master releasing the bus ends the transaction.
                    if (FRAME_ && IRDY_) begin
                        txnDone_d = 1'b1;
                        state_d   = TURN;
                    end
                end else begin
                    if (transfer && FRAME_) begin
                        txnDone_d = 1'b1;
                        state_d   = TURN;
                    end
                    if (DEVSEL_) begin
                        tmoCount_d = tmoInc;
                        if (tmoInc == TMO_LIMIT) begin
                            aborted_d = 1'b1;
                            newErr[3] = 1'b1;
                        end
                    end
                end
                if (!framePrev_q && FRAME_ && IRDY_) begin
                    newErr[0] = 1'b1;
                end
            end
            TURN: begin
                if (!FRAME_) begin
                    addrPhase = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (addrPhase) begin
            cmd_d       = C_BE_[3:0];
            beatCount_d = '0;
            tmoCount_d  = '0;
            aborted_d   = 1'b0;
            state_d     = DATA;
        end

        if (!TRDY_ && DEVSEL_) begin
            newErr[1] = 1'b1;
        end
        if (parPending_q && (PAR != ^{adPrev_q, cbePrev_q})) begin
            newErr[2] = 1'b1;
        end

        parPending_d = addrPhase || transfer;
        busy_d       = (state_d != IDLE);

        // A fresh error in the same cycle as a clear survives the clear.
        if (err_clr) begin
            errFlags_d = newErr;
        end else begin
            errFlags_d = errFlags_q | newErr;
        end
        if (|newErr) begin
            if (err_clr) begin
                errCount_d = CNT_WIDTH'(1);
            end else if (errCount_q != CNT_MAX) begin
                errCount_d = errInc;
            end else begin
                errCount_d = errCount_q;
            end
        end else if (err_clr) begin
            errCount_d = '0;
        end else begin
            errCount_d = errCount_q;
        end
    end

    // State and history registers with synchronous reset; reset drops any transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            cmd_q        <= '0;
            beatCount_q  <= '0;
            txnDone_q    <= 1'b0;
            errFlags_q   <= '0;
            errCount_q   <= '0;
            tmoCount_q   <= '0;
            aborted_q    <= 1'b0;
            parPending_q <= 1'b0;
            framePrev_q  <= 1'b0;
            adPrev_q     <= '0;
            cbePrev_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            cmd_q        <= cmd_d;
            beatCount_q  <= beatCount_d;
            txnDone_q    <= txnDone_d;
            errFlags_q   <= errFlags_d;
            errCount_q   <= errCount_d;
            tmoCount_q   <= tmoCount_d;
            aborted_q    <= aborted_d;
            parPending_q <= parPending_d;
            framePrev_q  <= FRAME_;
            adPrev_q     <= AD;
            cbePrev_q    <= C_BE_;
        end
    end

    assign busy       = busy_q;
    assign cmd        = cmd_q;
    assign beat_count = beatCount_q;
    assign txn_done   = txnDone_q;
    assign err_flags  = errFlags_q;
    assign err_count  = errCount_q;

`ifdef PCI_MON_XCHECK_EN
`ifndef SYNTHESIS
    // Simulation-only X/Z sanity checks on the bus, silent while reset is held.
    always @(posedge clk) begin
        if (!reset) begin
            if (addrPhase && $isunknown({AD, C_BE_})) begin
                $display("pci_protocol_monitor: X/Z on AD/C_BE_ in address phase at %0t", $time);
            end
            if (transfer && $isunknown({AD, C_BE_})) begin
                $display("pci_protocol_monitor: X/Z on AD/C_BE_ during transfer at %0t", $time);
            end
            if ((state_q == DATA) && $isunknown(C_BE_)) begin
                $display("pci_protocol_monitor: X/Z on C_BE_ in data phase at %0t", $time);
            end
        end
    end
`endif
`else
    // X/Z checks not built; monitor behaviour is unaffected.
`endif

endmodule
